// File: rtl/tx_pattern_gen.sv
// Parallel 16-bit test-pattern source: 16-step unrolled programmable LFSR,
// fixed/clock/idle words, handshaked single-bit error injection and status counters.
module tx_pattern_gen #(
  parameter logic [31:0] SEED_DEFAULT = 32'h0000_0001,
  parameter logic [31:0] EQN_DEFAULT  = 32'h0010_0002
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cke,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic [31:0] eqn,
  input  logic [1:0]  mode,
  input  logic [15:0] pat_word,
  input  logic        inj_req,
  input  logic [3:0]  inj_pos,
  output logic        inj_ack,
  output logic [15:0] dout,
  output logic [31:0] word_cnt,
  output logic [7:0]  inj_cnt,
  output logic        lock_err
);

  typedef enum logic [0:0] {INJ_IDLE = 1'b0, INJ_WAIT = 1'b1} inj_state_t;

  // Sixteen chained serial steps; first produced bit lands in word[15].
  function automatic logic [47:0] lfsr_unroll(input logic [31:0] state, input logic [31:0] taps);
    logic [31:0] st;
    logic [15:0] w;
    logic        b;
    st = state;
    w  = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      b         = ^(st & taps);
      w[15 - i] = b;
      st        = {st[30:0], b};
    end
    return {st, w};
  endfunction

  logic [31:0] lfsr_r;
  logic [31:0] eqn_r;
  inj_state_t  state_r;
  inj_state_t  state_next_s;
  logic [47:0] unroll_s;
  logic [15:0] prbs_word_s;
  logic [31:0] lfsr_next_s;
  logic        lock_hit_s;
  logic [15:0] pattern_s;
  logic        inj_fire_s;
  logic [15:0] inj_mask_s;

  // Unrolled LFSR next state and produced word.
  always_comb begin
    unroll_s    = lfsr_unroll(lfsr_r, eqn_r);
    prbs_word_s = unroll_s[15:0];
    lfsr_next_s = unroll_s[47:16];
    lock_hit_s  = (lfsr_next_s == 32'h0000_0000);
  end

  // Pattern selection.
  always_comb begin
    case (mode)
      2'd0:    pattern_s = prbs_word_s;
      2'd1:    pattern_s = pat_word;
      2'd2:    pattern_s = 16'hAAAA;
      2'd3:    pattern_s = 16'h0000;
      default: pattern_s = 16'h0000;
    endcase
  end

  // Injection FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= INJ_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Injection FSM next state; no transition while cke is low.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      INJ_IDLE: begin
        if (inj_req && cke) state_next_s = INJ_WAIT;
        else                state_next_s = INJ_IDLE;
      end
      INJ_WAIT: begin
        if (cke && !inj_req) state_next_s = INJ_IDLE;
        else                 state_next_s = INJ_WAIT;
      end
      default: state_next_s = INJ_IDLE;
    endcase
  end

  // Injection FSM outputs.
  always_comb begin
    inj_fire_s = 1'b0;
    if (state_r == INJ_IDLE && inj_req && cke) inj_fire_s = 1'b1;
    else                                       inj_fire_s = 1'b0;
    inj_mask_s = inj_fire_s ? (16'h0001 << inj_pos) : 16'h0000;
  end

  // LFSR state and tap mask; load wins, an all-zero successor restarts at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r <= SEED_DEFAULT;
      eqn_r  <= EQN_DEFAULT;
    end else if (load) begin
      lfsr_r <= (seed == 32'h0000_0000) ? 32'h0000_0001 : seed;
      eqn_r  <= eqn;
    end else if (cke) begin
      lfsr_r <= lock_hit_s ? 32'h0000_0001 : lfsr_next_s;
    end
  end

  // Output word, computed from the pre-load state even in a load cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout    <= 16'h0000;
      inj_ack <= 1'b0;
    end else begin
      if (cke) dout <= pattern_s ^ inj_mask_s;
      inj_ack <= inj_fire_s;
    end
  end

  // Status counters and sticky lock-up flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= 32'h0000_0000;
      inj_cnt  <= 8'h00;
      lock_err <= 1'b0;
    end else begin
      if (load) begin
        word_cnt <= 32'h0000_0000;
        lock_err <= 1'b0;
      end else if (cke) begin
        if (word_cnt != 32'hFFFF_FFFF) word_cnt <= word_cnt + 32'h0000_0001;
        if (lock_hit_s) lock_err <= 1'b1;
      end
      if (inj_fire_s && inj_cnt != 8'hFF) inj_cnt <= inj_cnt + 8'h01;
    end
  end

endmodule

// File: tb/tb_tx_pattern_gen.sv
// Directed self-checking bench for tx_pattern_gen with a bit-serial LFSR reference.
module tb_tx_pattern_gen;

  logic        clk = 1'b0;
  logic        rst_n, cke, load, inj_req, inj_ack, lock_err;
  logic [31:0] seed, eqn, word_cnt;
  logic [1:0]  mode;
  logic [15:0] pat_word, dout;
  logic [3:0]  inj_pos;
  logic [7:0]  inj_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_s, m_e;

  tx_pattern_gen dut (
    .clk(clk), .rst_n(rst_n), .cke(cke), .load(load), .seed(seed), .eqn(eqn),
    .mode(mode), .pat_word(pat_word), .inj_req(inj_req), .inj_pos(inj_pos),
    .inj_ack(inj_ack), .dout(dout), .word_cnt(word_cnt), .inj_cnt(inj_cnt),
    .lock_err(lock_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serial reference: shift one bit at a time, restart at 1 on an all-zero state.
  task automatic model_word(output logic [15:0] w);
    logic b;
    w = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      b   = ^(m_s & m_e);
      w   = {w[14:0], b};
      m_s = {m_s[30:0], b};
    end
    if (m_s == 32'h0) m_s = 32'h1;
  endtask

  task automatic do_load(input logic [31:0] sd, input logic [31:0] eq);
    cke = 1'b0; seed = sd; eqn = eq; load = 1'b1;
    tick();
    load = 1'b0;
    m_s = (sd == 32'h0) ? 32'h1 : sd;
    m_e = eq;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cke = 1'b0; load = 1'b0; seed = 32'h0; eqn = 32'h0; mode = 2'd0;
    pat_word = 16'h0; inj_req = 1'b0; inj_pos = 4'd0;
    #3;
    n_cmp++; if (dout !== 16'h0000) begin n_bad++; $display("FAIL reset_dout got %h want 0000", dout); end
    n_cmp++; if (word_cnt !== 32'h0) begin n_bad++; $display("FAIL reset_word_cnt got %h want 0", word_cnt); end
    n_cmp++; if ({inj_ack, inj_cnt, lock_err} !== 10'h0) begin n_bad++; $display("FAIL reset_flags got %b/%h/%b want 0", inj_ack, inj_cnt, lock_err); end
    tick(); tick();
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_prbs7();
    logic [15:0] words [0:127];
    logic [15:0] e;
    int ones, early, bad;
    do_load(32'h0000_007F, 32'h0000_0060);
    n_cmp++; if (word_cnt !== 32'h0) begin n_bad++; $display("FAIL load_word_cnt got %h want 0", word_cnt); end
    cke = 1'b1; mode = 2'd0;
    bad = 0;
    for (int i = 0; i < 128; i++) begin
      tick();
      model_word(e);
      words[i] = dout;
      if (dout !== e) bad++;
      if (i == 126) begin
        n_cmp++; if (word_cnt !== 32'd127) begin n_bad++; $display("FAIL prbs7_word_cnt got %0d want 127", word_cnt); end
      end
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL prbs7_stream got %0d bad words want 0", bad); end
    early = 0;
    for (int i = 1; i < 127; i++) if (words[i] === words[0]) early++;
    n_cmp++; if (words[127] !== words[0] || early != 0) begin n_bad++; $display("FAIL prbs7_period got w127=%h w0=%h early=%0d want repeat at 127 only", words[127], words[0], early); end
    ones = 0;
    for (int k = 0; k < 127; k++) ones += int'(words[k / 16][15 - (k % 16)]);
    n_cmp++; if (ones != 64) begin n_bad++; $display("FAIL prbs7_ones got %0d want 64", ones); end
  endtask

  task automatic test_modes();
    logic [15:0] e;
    mode = 2'd2; tick(); model_word(e);
    n_cmp++; if (dout !== 16'hAAAA) begin n_bad++; $display("FAIL mode_clock got %h want aaaa", dout); end
    mode = 2'd1; pat_word = 16'h1234; tick(); model_word(e);
    n_cmp++; if (dout !== 16'h1234) begin n_bad++; $display("FAIL mode_fixed got %h want 1234", dout); end
    mode = 2'd3; tick(); model_word(e);
    n_cmp++; if (dout !== 16'h0000) begin n_bad++; $display("FAIL mode_idle got %h want 0000", dout); end
    mode = 2'd0;
    for (int i = 0; i < 3; i++) begin
      tick(); model_word(e);
      n_cmp++; if (dout !== e) begin n_bad++; $display("FAIL mode_resume got %h want %h", dout, e); end
    end
  endtask

  task automatic test_inject();
    logic [15:0] e;
    int diffs, acks, other;
    diffs = 0; acks = 0; other = 0;
    inj_req = 1'b1; inj_pos = 4'd5;
    for (int i = 0; i < 10; i++) begin
      tick(); model_word(e);
      if ((dout ^ e) == 16'h0020) diffs++;
      else if (dout !== e) other++;
      if (inj_ack === 1'b1) acks++;
    end
    inj_req = 1'b0;
    n_cmp++; if (diffs != 1 || other != 0) begin n_bad++; $display("FAIL inj_words got %0d flips %0d other want 1 0", diffs, other); end
    n_cmp++; if (acks != 1) begin n_bad++; $display("FAIL inj_ack_count got %0d want 1", acks); end
    n_cmp++; if (inj_cnt !== 8'd1) begin n_bad++; $display("FAIL inj_cnt1 got %0d want 1", inj_cnt); end
    tick(); model_word(e);
    inj_req = 1'b1; tick(); model_word(e);
    n_cmp++; if (dout !== (e ^ 16'h0020) || inj_ack !== 1'b1) begin n_bad++; $display("FAIL inj_second got %h ack %b want %h ack 1", dout, inj_ack, e ^ 16'h0020); end
    inj_req = 1'b0; tick(); model_word(e);
    n_cmp++; if (inj_cnt !== 8'd2 || inj_ack !== 1'b0) begin n_bad++; $display("FAIL inj_cnt2 got %0d ack %b want 2 ack 0", inj_cnt, inj_ack); end
  endtask

  task automatic test_lockup();
    logic [15:0] e, first;
    int same;
    do_load(32'h0, 32'h0000_0060);
    cke = 1'b1; same = 0;
    for (int i = 0; i < 4; i++) begin
      tick(); model_word(e);
      if (i == 0) first = dout; else if (dout === first) same++;
      n_cmp++; if (dout !== e) begin n_bad++; $display("FAIL zero_seed got %h want %h", dout, e); end
    end
    n_cmp++; if (same == 3) begin n_bad++; $display("FAIL zero_seed_const got constant %h want varying", first); end
    do_load(32'h8000_0000, 32'h0000_0001);
    n_cmp++; if (lock_err !== 1'b0) begin n_bad++; $display("FAIL lock_clear got %b want 0", lock_err); end
    cke = 1'b1; tick(); model_word(e);
    n_cmp++; if (lock_err !== 1'b1 || dout !== 16'h0000) begin n_bad++; $display("FAIL lock_set got %b/%h want 1/0000", lock_err, dout); end
    tick(); model_word(e);
    n_cmp++; if (dout !== 16'hFFFF || lock_err !== 1'b1) begin n_bad++; $display("FAIL lock_restart got %h/%b want ffff/1", dout, lock_err); end
  endtask

  task automatic test_cke_hold();
    logic [15:0] e, held;
    logic [31:0] cnt;
    do_load(32'h0000_007F, 32'h0000_0060);
    cke = 1'b1; mode = 2'd0;
    for (int i = 0; i < 3; i++) begin tick(); model_word(e); end
    held = dout; cnt = word_cnt;
    cke = 1'b0; inj_req = 1'b1; inj_pos = 4'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (dout !== held || word_cnt !== cnt || inj_ack !== 1'b0) begin n_bad++; $display("FAIL cke_freeze got %h/%0d/%b want %h/%0d/0", dout, word_cnt, inj_ack, held, cnt); end
    end
    n_cmp++; if (inj_cnt !== 8'd2) begin n_bad++; $display("FAIL cke_inj_cnt got %0d want 2", inj_cnt); end
    cke = 1'b1; tick(); model_word(e);
    n_cmp++; if (dout !== (e ^ 16'h0001) || inj_ack !== 1'b1) begin n_bad++; $display("FAIL cke_pending_inj got %h ack %b want %h ack 1", dout, inj_ack, e ^ 16'h0001); end
    tick(); model_word(e);
    inj_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); model_word(e);
      n_cmp++; if (dout !== e) begin n_bad++; $display("FAIL cke_resume got %h want %h", dout, e); end
    end
    n_cmp++; if (word_cnt !== 32'd8 || inj_cnt !== 8'd3) begin n_bad++; $display("FAIL cke_counts got %0d/%0d want 8/3", word_cnt, inj_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] e;
    inj_req = 1'b1; inj_pos = 4'd5;
    tick(); tick();
    n_cmp++; if (inj_cnt !== 8'd4) begin n_bad++; $display("FAIL pre_reset_inj_cnt got %0d want 4", inj_cnt); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (dout !== 16'h0 || word_cnt !== 32'h0 || inj_cnt !== 8'h0 || inj_ack !== 1'b0 || lock_err !== 1'b0) begin
      n_bad++; $display("FAIL async_reset got %h/%0d/%0d/%b/%b want all 0", dout, word_cnt, inj_cnt, inj_ack, lock_err);
    end
    @(negedge clk) rst_n = 1'b1;
    m_s = 32'h0000_0001; m_e = 32'h0010_0002;
    tick(); model_word(e);
    n_cmp++; if (dout !== (e ^ 16'h0020) || inj_ack !== 1'b1 || inj_cnt !== 8'd1) begin
      n_bad++; $display("FAIL post_reset_inj got %h/%b/%0d want %h/1/1", dout, inj_ack, inj_cnt, e ^ 16'h0020);
    end
    inj_req = 1'b0;
    tick(); model_word(e);
    n_cmp++; if (dout !== e || word_cnt !== 32'd2) begin n_bad++; $display("FAIL post_reset_seq got %h/%0d want %h/2", dout, word_cnt, e); end
  endtask

  initial begin
    test_reset();
    test_prbs7();
    test_modes();
    test_inject();
    test_lockup();
    test_cke_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
